// File: rtl/mem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mem_pkg : shared constants and state encoding for the data-memory responder |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package mem_pkg;

    localparam int WORD_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | data_mem_responder_if : core data-port request/response bundle              |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface data_mem_responder_if;
    import mem_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [2:0]        funct3;
    logic [WORD_W-1:0] rdata;
    logic              mem_ready;
    logic              mem_err;
    logic              busy;

    modport master (
        output mem_read, mem_write, addr, wdata, funct3,
        input  rdata, mem_ready, mem_err, busy
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata, funct3,
        output rdata, mem_ready, mem_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mem_lane_align : byte/half lane extraction for loads, lane merge for stores |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module mem_lane_align
    import mem_pkg::*;
(
    input  wire [WORD_W-1:0] i_word,
    input  wire [1:0]        i_lane,
    input  wire [2:0]        i_funct3,
    input  wire [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_load_data,
    output logic [WORD_W-1:0] o_store_word
);

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [3:0]        lane_mask;
    logic [WORD_W-1:0] lane_data;

    always_comb begin
        byte_sel = i_word[7:0];
        unique case (i_lane)
            2'd0:    byte_sel = i_word[7:0];
            2'd1:    byte_sel = i_word[15:8];
            2'd2:    byte_sel = i_word[23:16];
            default: byte_sel = i_word[31:24];
        endcase
        half_sel = i_lane[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            F3_B:    o_load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   o_load_data = {24'd0, byte_sel};
            F3_H:    o_load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   o_load_data = {16'd0, half_sel};
            F3_W:    o_load_data = i_word;
            default: o_load_data = '0;
        endcase
    end

    // Store data is replicated across lanes so the mask alone picks the target.
    always_comb begin
        lane_mask = 4'b0000;
        lane_data = i_wdata;
        case (i_funct3)
            F3_B: begin
                lane_mask = 4'b0001 << i_lane;
                lane_data = {4{i_wdata[7:0]}};
            end
            F3_H: begin
                lane_mask = i_lane[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{i_wdata[15:0]}};
            end
            F3_W: begin
                lane_mask = 4'b1111;
                lane_data = i_wdata;
            end
            default: begin
                lane_mask = 4'b0000;
                lane_data = i_wdata;
            end
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign o_store_word[8*g +: 8] = lane_mask[g] ? lane_data[8*g +: 8] : i_word[8*g +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | data_mem_responder : wait-stated word RAM answering core load/store requests|
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  wire                 clk,
    input  wire                 resetn,
    data_mem_responder_if.slave bus
);

    localparam int          IDX_W        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] C_ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  C_WAIT_INIT  = 4'(WAIT_CYCLES);

    mem_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        lane_q, lane_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              is_write_q, is_write_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              mem_ready_q, mem_ready_d;
    logic              mem_err_q, mem_err_d;
    logic              busy_q, busy_d;

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    logic              req;
    logic              req_err;
    logic              f3_ok;
    logic              misaligned;
    logic [WORD_W-1:0] word_rd;
    logic [WORD_W-1:0] load_data;
    logic [WORD_W-1:0] store_word;

    assign req = bus.mem_read | bus.mem_write;

    always_comb begin
        f3_ok      = 1'b0;
        misaligned = 1'b0;
        case (bus.funct3)
            F3_B:  f3_ok = 1'b1;
            F3_H:  begin f3_ok = 1'b1;            misaligned = bus.addr[0];    end
            F3_W:  begin f3_ok = 1'b1;            misaligned = |bus.addr[1:0]; end
            F3_BU: f3_ok = ~bus.mem_write;
            F3_HU: begin f3_ok = ~bus.mem_write;  misaligned = bus.addr[0];    end
            default: ;
        endcase
        req_err = (bus.mem_read & bus.mem_write) | ~f3_ok | misaligned
                | ({1'b0, bus.addr} >= C_ADDR_LIMIT);
    end

    // Request fields are latched only in IDLE, so later input changes are ignored.
    always_comb begin
        idx_d      = idx_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        is_write_d = is_write_q;
        err_d      = err_q;
        if (state_q == IDLE && req) begin
            idx_d      = bus.addr[IDX_W+1:2];
            lane_d     = bus.addr[1:0];
            wdata_d    = bus.wdata;
            funct3_d   = bus.funct3;
            is_write_d = bus.mem_write;
            err_d      = req_err;
        end
    end

    // Reading at idx_d lets a zero-wait build respond in the cycle after capture.
    assign word_rd = mem_q[idx_d];

    mem_lane_align u_align (
        .i_word       (word_rd),
        .i_lane       (lane_d),
        .i_funct3     (funct3_d),
        .i_wdata      (wdata_d),
        .o_load_data  (load_data),
        .o_store_word (store_word)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_ready_d = 1'b0;
        mem_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d   = C_WAIT_INIT;
                    state_d = (C_WAIT_INIT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = RESP;
            end
            RESP:    state_d = DRAIN;
            DRAIN:   if (!req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == RESP) begin
            mem_ready_d = 1'b1;
            mem_err_d   = err_d;
            rdata_d     = (err_d || is_write_d) ? '0 : load_data;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            lane_q      <= 2'd0;
            wdata_q     <= '0;
            funct3_q    <= 3'd0;
            is_write_q  <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            is_write_q  <= is_write_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_ready_q <= mem_ready_d;
            mem_err_q   <= mem_err_d;
            busy_q      <= busy_d;
        end
    end

    // Commit happens on the edge leaving RESP; reset forces IDLE first, discarding it.
    always_ff @(posedge clk) begin
        if (state_q == RESP && is_write_q && !err_q) begin
            mem_q[idx_q] <= store_word;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_err   = mem_err_q;
    assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_data_mem_responder : directed self-checking bench (2-wait and 0-wait)    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    data_mem_responder_if bus ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit sel, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        if (sel) begin
            bus0.mem_read = rd; bus0.mem_write = wr; bus0.addr = a; bus0.wdata = wd; bus0.funct3 = f3;
        end else begin
            bus.mem_read = rd;  bus.mem_write = wr;  bus.addr = a;  bus.wdata = wd;  bus.funct3 = f3;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? bus0.mem_ready : bus.mem_ready;
    endfunction

    function automatic logic bsy(input bit sel);
        return sel ? bus0.busy : bus.busy;
    endfunction

    // Latency counts rising edges from the capture edge up to the one raising mem_ready.
    task automatic do_req(input bit sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                          output logic [31:0] data, output logic err, output int lat);
        bit got = 0;
        int n = 0;
        @(negedge clk);
        set_req(sel, rd, wr, a, wd, f3);
        lat = 0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rdy(sel)) got = 1;
        end
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
        data = sel ? bus0.rdata : bus.rdata;
        err  = sel ? bus0.mem_err : bus.mem_err;
        @(negedge clk);
        set_req(sel, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        while (bsy(sel) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (bsy(sel)) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic load_chk(input string tag, input bit sel, input logic [31:0] a,
                            input logic [2:0] f3, input logic [31:0] exp, input int exp_lat);
        logic [31:0] d;
        logic        e;
        int          l;
        do_req(sel, 1'b1, 1'b0, a, 32'd0, f3, d, e, l);
        chk({tag, "_data"}, d, exp);
        chk({tag, "_err"}, {31'd0, e}, 32'd0);
        chk({tag, "_lat"}, l, exp_lat);
    endtask

    task automatic err_chk(input string tag, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] d;
        logic        e;
        int          l;
        do_req(1'b0, rd, wr, a, 32'hFFFF_FFFF, f3, d, e, l);
        chk({tag, "_err"}, {31'd0, e}, 32'd1);
        chk({tag, "_data"}, d, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          l;
        int          pulses;
        bit          busy_dropped;

        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_ctrl", {29'd0, bus.mem_ready, bus.mem_err, bus.busy}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Word store then load.
        do_req(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, W, d, e, l);
        chk("sw_lat", l, 3);
        chk("sw_err", {31'd0, e}, 32'd0);
        load_chk("lw10", 1'b0, 32'h10, W, 32'hDEAD_BEEF, 3);

        // Sub-word loads with sign / zero extension.
        load_chk("lb13",  1'b0, 32'h13, B,  32'hFFFF_FFDE, 3);
        load_chk("lbu13", 1'b0, 32'h13, BU, 32'h0000_00DE, 3);
        load_chk("lh10",  1'b0, 32'h10, H,  32'hFFFF_BEEF, 3);
        load_chk("lhu12", 1'b0, 32'h12, HU, 32'h0000_DEAD, 3);

        // Lane-merging stores.
        do_req(1'b0, 1'b0, 1'b1, 32'h11, 32'h0000_0055, B, d, e, l);
        load_chk("lw_sb", 1'b0, 32'h10, W, 32'hDEAD_55EF, 3);
        do_req(1'b0, 1'b0, 1'b1, 32'h12, 32'h0000_1234, H, d, e, l);
        load_chk("lw_sh", 1'b0, 32'h10, W, 32'h1234_55EF, 3);

        // Rejected requests leave RAM untouched.
        err_chk("lw_mis",  1'b1, 1'b0, 32'h12, W);
        err_chk("lh_mis",  1'b1, 1'b0, 32'h11, H);
        err_chk("rdwr",    1'b1, 1'b1, 32'h10, W);
        err_chk("sw_oob",  1'b0, 1'b1, 32'h1000, W);
        err_chk("sbu_ill", 1'b0, 1'b1, 32'h10, BU);
        err_chk("f3_ill",  1'b1, 1'b0, 32'h10, 3'b011);
        load_chk("lw_after_err", 1'b0, 32'h10, W, 32'h1234_55EF, 3);

        // Held request: one response only, busy held through DRAIN.
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, W);
        pulses = 0;
        busy_dropped = 0;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            if (bus.mem_ready) pulses++;
            if (pulses > 0 && !bus.busy) busy_dropped = 1;
        end
        chk("hold_pulses", pulses, 1);
        chk("hold_busy", {31'd0, busy_dropped}, 32'd0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        @(posedge clk); #1;
        chk("drain_exit_busy", {31'd0, bus.busy}, 32'd0);
        load_chk("reassert", 1'b0, 32'h10, W, 32'h1234_55EF, 3);

        // Reset during WAIT discards the captured store.
        do_req(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, W, d, e, l);
        load_chk("lw20", 1'b0, 32'h20, W, 32'hCAFE_F00D, 3);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b1, 32'h20, 32'h0000_0001, W);
        @(posedge clk); #1;
        chk("wait_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_rst_rdata", bus.rdata, 32'd0);
        chk("mid_rst_ctrl", {29'd0, bus.mem_ready, bus.mem_err, bus.busy}, 32'd0);
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        load_chk("lw20_post_rst", 1'b0, 32'h20, W, 32'hCAFE_F00D, 3);

        // Zero-wait instance.
        do_req(1'b1, 1'b0, 1'b1, 32'h4, 32'hA5A5_1234, W, d, e, l);
        chk("w0_sw_lat", l, 1);
        load_chk("w0_lw",  1'b1, 32'h4, W,  32'hA5A5_1234, 1);
        load_chk("w0_lhu", 1'b1, 32'h6, HU, 32'h0000_A5A5, 1);
        do_req(1'b1, 1'b1, 1'b0, 32'h40, 32'd0, W, d, e, l);
        chk("w0_oob_err", {31'd0, e}, 32'd1);
        chk("w0_oob_data", d, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
